inv_mixcolumns_seq: RTL and testbench



---
 rtl/inv_mixcolumns_seq.sv | 189 ++++++++++++++++++
 tb/tb_inv_mixcolumns_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns engine: one 128-bit state in over a valid/ready
// handshake, one 32-bit column transformed per cycle, result returned over a
// second valid/ready handshake.
// Optional build macro INV_MC_FWD_EN adds a 'fwd' input that selects the
// forward MixColumns matrix for the captured state.
module inv_mixcolumns_seq #(
  parameter int unsigned NCOLS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NCOLS-1:0]    in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NCOLS-1:0]    out_state,
  output logic                   busy
`ifdef INV_MC_FWD_EN
  ,
  input  logic                   fwd
`endif
);

  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = COL_W * NCOLS;
  localparam int unsigned CNT_W   = $clog2(NCOLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [COL_W-1:0]   col_in;
  logic [COL_W-1:0]   col_out;
`ifdef INV_MC_FWD_EN
  logic               fwd_q, fwd_d;
`endif

  // GF(2^8) multiply by x, reduced modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Products of one byte with the inverse coefficients, packed {0e, 0b, 0d, 09}
  function automatic logic [31:0] inv_terms(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    inv_terms = {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  // Inverse column transform; byte 0 of the column sits in the MSBs
  function automatic logic [31:0] col_inv(input logic [31:0] c);
    logic [31:0] t0, t1, t2, t3;
    t0 = inv_terms(c[31:24]);
    t1 = inv_terms(c[23:16]);
    t2 = inv_terms(c[15:8]);
    t3 = inv_terms(c[7:0]);
    // each tN is {e, b, d, 9} for input byte N
    col_inv[31:24] = t0[31:24] ^ t1[23:16] ^ t2[15:8]  ^ t3[7:0];
    col_inv[23:16] = t0[7:0]   ^ t1[31:24] ^ t2[23:16] ^ t3[15:8];
    col_inv[15:8]  = t0[15:8]  ^ t1[7:0]   ^ t2[31:24] ^ t3[23:16];
    col_inv[7:0]   = t0[23:16] ^ t1[15:8]  ^ t2[7:0]   ^ t3[31:24];
  endfunction

`ifdef INV_MC_FWD_EN
  // Forward column transform, circulant {02 03 01 01}
  function automatic logic [31:0] col_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    col_fwd[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    col_fwd[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    col_fwd[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    col_fwd[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  endfunction
`endif

  // Select the column addressed by the counter
  always_comb begin
    col_in = work_q[STATE_W-1 -: COL_W];
    case (cnt_q)
      CNT_W'(1): col_in = work_q[STATE_W-1-COL_W   -: COL_W];
      CNT_W'(2): col_in = work_q[STATE_W-1-2*COL_W -: COL_W];
      CNT_W'(3): col_in = work_q[STATE_W-1-3*COL_W -: COL_W];
      default:   col_in = work_q[STATE_W-1 -: COL_W];
    endcase
  end

  // Single shared column unit
`ifdef INV_MC_FWD_EN
  always_comb begin
    col_out = fwd_q ? col_fwd(col_in) : col_inv(col_in);
  end
`else
  always_comb begin
    col_out = col_inv(col_in);
  end
`endif

  // State, counter, work register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef INV_MC_FWD_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef INV_MC_FWD_EN
      fwd_q       <= fwd_d;
`endif
    end
  end

  // Next-state logic; flag outputs are decoded from the next state so they
  // are registered and carry no path from in_valid or out_ready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef INV_MC_FWD_EN
    fwd_d   = fwd_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef INV_MC_FWD_EN
          fwd_d   = fwd;
`endif
        end
      end
      S_BUSY: begin
        case (cnt_q)
          CNT_W'(1): work_d[STATE_W-1-COL_W   -: COL_W] = col_out;
          CNT_W'(2): work_d[STATE_W-1-2*COL_W -: COL_W] = col_out;
          CNT_W'(3): work_d[STATE_W-1-3*COL_W -: COL_W] = col_out;
          default:   work_d[STATE_W-1 -: COL_W]         = col_out;
        endcase
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCOLS - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_BUSY) || (state_d == S_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// Self-checking bench for inv_mixcolumns_seq: directed vectors with literal
// expectations plus a per-cycle compare against a matrix-product model.
module tb_inv_mixcolumns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic         fwd;

  int checks   = 0;
  int failures = 0;

  inv_mixcolumns_seq #(.NCOLS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
`ifdef INV_MC_FWD_EN
    ,
    .fwd       (fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Shift-and-add GF(2^8) product modulo 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return 8'(p);
  endfunction

  // Matrix product of a circulant coefficient row with every column
  function automatic logic [127:0] model(input logic [127:0] st, input logic f);
    logic [7:0]   coef [4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (f) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(coef[(j - r + 4) % 4], st[127 - 32*c - 8*j -: 8]);
        end
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  // Transaction-level expectation, checked and advanced on every falling edge
  logic         m_idle = 1'b1;
  logic         m_done = 1'b0;
  int           m_rem  = 0;
  logic [127:0] m_exp  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_rem  = 0;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_out_state", out_state, '0);
    end else begin
      chk("cyc_in_ready", 128'(in_ready), 128'(m_idle));
      chk("cyc_out_valid", 128'(out_valid), 128'(m_done));
      chk("cyc_busy", 128'(busy), 128'(!m_idle));
      if (m_done) chk("cyc_out_state", out_state, m_exp);
      if (m_idle) begin
        if (in_valid) begin
          m_exp  = model(in_state, fwd);
          m_idle = 1'b0;
          m_rem  = 4;
        end
      end else if (!m_done) begin
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end else if (out_ready) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  // One transaction; leaves the block in DONE when out_ready is low
  task automatic run_vec(input string nm, input logic [127:0] din, input logic f,
                         input logic [127:0] exp, output logic [127:0] got);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_ready_wait"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_state = din;
    fwd      = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'(4));
    chk(nm, out_state, exp);
    got = out_state;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  logic [127:0] got;
  logic [127:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b1;
    fwd       = 1'b0;
    got       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_state", out_state, '0);
    chk("reset_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("known", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0,
            128'hdb135345_f20a225c_01010101_c6c6c6c6, got);
    run_vec("zero", '0, 1'b0, '0, got);
    run_vec("fixed", 128'hd5d5d7d6_4d7ebdf8_00000000_01010101, 1'b0,
            128'hd4d4d4d5_2d26314c_00000000_01010101, got);

    // Backpressure: hold DONE, pulse in_valid, then release
    out_ready = 1'b0;
    run_vec("bp", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0,
            128'hdb135345_f20a225c_01010101_c6c6c6c6, held);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_state = 128'hffffffff_00000000_12345678_9abcdef0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_state = '0;
      if (i % 3 == 0) begin
        chk("bp_stable", out_state, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_out_valid", 128'(out_valid), 128'(1));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    chk("bp_release_ready", 128'(in_ready), 128'(1));

    // Reset two cycles after accept
    in_valid = 1'b1;
    in_state = 128'hd5d5d7d6_4d7ebdf8_00000000_01010101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_state", out_state, '0);
    chk("midrst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after_rst", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0,
            128'hdb135345_f20a225c_01010101_c6c6c6c6, got);

`ifdef INV_MC_FWD_EN
    run_vec("fwd1", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, got);
    run_vec("fwd0", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
            model(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0), got);
    held = 128'h00112233_44556677_8899aabb_ccddeeff;
    run_vec("rt_fwd", held, 1'b1, model(held, 1'b1), got);
    run_vec("rt_inv", got, 1'b0, 128'h00112233_44556677_8899aabb_ccddeeff, got);
    fwd = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
